uart8_tx_fifo: RTL and testbench

//  Byte FIFO that sits directly upstream of the 8-bit UART transmit path.

---
 rtl/uart8_tx_fifo_pkg.sv | 12 +
 rtl/uart8_tx_fifo_if.sv | 30 +++
 rtl/uart8_fifo_mem.sv | 38 +++
 rtl/uart8_tx_fifo.sv | 108 ++++++++++
 tb/tb_uart8_tx_fifo.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/uart8_tx_fifo_pkg.sv
// Shared definitions for the UART transmit FIFO: byte width and drain FSM encoding.
package uart8_tx_fifo_pkg;

  localparam int unsigned ByteW = 8;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StStart = 2'd1,
    StWait  = 2'd2
  } drainState_e;

endpackage

// File: rtl/uart8_tx_fifo_if.sv
// Host write port plus transmitter handshake for uart8_tx_fifo.
interface uart8_tx_fifo_if #(
  parameter int unsigned DEPTH = 16
);
  import uart8_tx_fifo_pkg::*;

  localparam int unsigned ADDR_W = $clog2(DEPTH);

  logic             wrEn;
  logic [ByteW-1:0] wrData;
  logic             full;
  logic             empty;
  logic [ADDR_W:0]  count;
  logic             overflow;
  logic             ovfClr;
  logic             txStart;
  logic [ByteW-1:0] txIn;
  logic             txBusy;

  modport master (
    output wrEn, wrData, ovfClr, txBusy,
    input  full, empty, count, overflow, txStart, txIn
  );

  modport slave (
    input  wrEn, wrData, ovfClr, txBusy,
    output full, empty, count, overflow, txStart, txIn
  );

endinterface

// File: rtl/uart8_fifo_mem.sv
// DEPTH x 8 FIFO storage: one write port, one registered read port.
module uart8_fifo_mem
  import uart8_tx_fifo_pkg::*;
#(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wrEn,
  input  logic [ADDR_W-1:0] wrAddr,
  input  logic [ByteW-1:0]  wrData,
  input  logic              rdEn,
  input  logic [ADDR_W-1:0] rdAddr,
  output logic [ByteW-1:0]  rdData
);

  logic [ByteW-1:0] memQ [DEPTH];
  logic [ByteW-1:0] rdDataQ;

  always_ff @(posedge clk) begin
    if (wrEn) begin
      memQ[wrAddr] <= wrData;
    end
  end

  // The read register doubles as the byte presented to the transmitter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdDataQ <= '0;
    end else if (rdEn) begin
      rdDataQ <= memQ[rdAddr];
    end
  end

  assign rdData = rdDataQ;

endmodule

// File: rtl/uart8_tx_fifo.sv
// Byte FIFO draining into an 8-bit UART transmitter via txStart/txIn/txBusy.
// Define UART8_TX_FIFO_SYNC_EN to pass txBusy through a 2-flop synchroniser.
module uart8_tx_fifo
  import uart8_tx_fifo_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input logic            clk,
  input logic            reset,
  uart8_tx_fifo_if.slave bus
);

  localparam int unsigned ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0]   FullCount = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   CountOne  = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] PtrOne    = ADDR_W'(1);

  logic [ADDR_W-1:0] wrPtrQ, rdPtrQ;
  logic [ADDR_W:0]   countQ, countD;
  logic              ovfQ;
  drainState_e       stateQ, stateD;
  logic              busyS;
  logic              push, pop, drop, isFull, isEmpty;

`ifdef UART8_TX_FIFO_SYNC_EN
  logic [1:0] busySyncQ;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busySyncQ <= '0;
    end else begin
      busySyncQ <= {busySyncQ[0], bus.txBusy};
    end
  end

  assign busyS = busySyncQ[1];
`else
  assign busyS = bus.txBusy;
`endif

  assign isFull  = (countQ == FullCount);
  assign isEmpty = (countQ == '0);
  // Both decisions use pre-edge occupancy; a same-cycle pop never frees a slot.
  assign push = bus.wrEn && !isFull;
  assign drop = bus.wrEn && isFull;
  assign pop  = (stateQ == StIdle) && !isEmpty;

  always_comb begin
    countD = countQ;
    if (push && !pop) begin
      countD = countQ + CountOne;
    end else if (pop && !push) begin
      countD = countQ - CountOne;
    end
  end

  always_comb begin
    stateD = stateQ;
    case (stateQ)
      StIdle:  if (!isEmpty) stateD = StStart;
      StStart: if (busyS)    stateD = StWait;
      StWait:  if (!busyS)   stateD = StIdle;
      default:               stateD = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrPtrQ <= '0;
      rdPtrQ <= '0;
      countQ <= '0;
      ovfQ   <= 1'b0;
      stateQ <= StIdle;
    end else begin
      if (push) wrPtrQ <= wrPtrQ + PtrOne;
      if (pop)  rdPtrQ <= rdPtrQ + PtrOne;
      countQ <= countD;
      // A drop outranks a simultaneous clear.
      if (drop) begin
        ovfQ <= 1'b1;
      end else if (bus.ovfClr) begin
        ovfQ <= 1'b0;
      end
      stateQ <= stateD;
    end
  end

  uart8_fifo_mem #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) uMem (
    .clk    (clk),
    .reset  (reset),
    .wrEn   (push),
    .wrAddr (wrPtrQ),
    .wrData (bus.wrData),
    .rdEn   (pop),
    .rdAddr (rdPtrQ),
    .rdData (bus.txIn)
  );

  assign bus.txStart  = (stateQ == StStart);
  assign bus.full     = isFull;
  assign bus.empty    = isEmpty;
  assign bus.count    = countQ;
  assign bus.overflow = ovfQ;

endmodule

// File: tb/tb_uart8_tx_fifo.sv
// Scoreboard bench for uart8_tx_fifo with a behavioural transmitter and FIFO model.
module tb_uart8_tx_fifo;

  localparam int unsigned DEPTH = 16;
`ifdef UART8_TX_FIFO_SYNC_EN
  localparam int SyncLat = 2;
`else
  localparam int SyncLat = 0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;

  uart8_tx_fifo_if #(.DEPTH(DEPTH)) bus ();

  uart8_tx_fifo #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference: bytes accepted but not yet handed to the transmitter, in order.
  logic [7:0] expQ[$];
  logic       modelOvf = 1'b0;
  logic       prevStart = 1'b0;
  logic [7:0] lastTx = 8'h00;
  int         preSize;
  logic       acc, drp, popped;

  int frames = 0;
  int busyLen = 5;
  bit stall = 1'b0;
  bit txEnable = 1'b1;
  bit randBusy = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor/scoreboard: judges each edge from pre-edge model occupancy.
  always @(posedge clk) begin
    #1;
    if (reset) begin
      expQ.delete();
      modelOvf  = 1'b0;
      prevStart = 1'b0;
    end else begin
      preSize = expQ.size();
      acc     = bus.wrEn && (preSize < DEPTH);
      drp     = bus.wrEn && !acc;
      popped  = bus.txStart && !prevStart;
      if (popped) begin
        if (preSize == 0) begin
          checks++;
          failures++;
          $display("FAIL spurious_pop: txIn 0x%0h sent with model empty at %0t", bus.txIn, $time);
        end else begin
          check("tx_data", bus.txIn, expQ.pop_front());
        end
        lastTx = bus.txIn;
      end else if (bus.txStart) begin
        check("tx_stable", bus.txIn, lastTx);
      end
      if (acc) expQ.push_back(bus.wrData);
      modelOvf = drp ? 1'b1 : (bus.ovfClr ? 1'b0 : modelOvf);
      check("count", bus.count, expQ.size());
      check("full", bus.full, expQ.size() == DEPTH);
      check("empty", bus.empty, expQ.size() == 0);
      check("overflow", bus.overflow, modelOvf);
      prevStart = bus.txStart;
    end
  end

  // Transmitter model: goes busy one clk after seeing txStart.
  initial begin
    int len;
    bus.txBusy = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.txStart && !bus.txBusy && txEnable && !reset) begin
        bus.txBusy = 1'b1;
        frames++;
        len = randBusy ? int'($urandom_range(4, 9)) : busyLen;
        repeat (len) @(negedge clk);
        while (stall) @(negedge clk);
        bus.txBusy = 1'b0;
      end
    end
  end

  task automatic writeByte(input logic [7:0] d);
    @(negedge clk);
    bus.wrEn   = 1'b1;
    bus.wrData = d;
    @(negedge clk);
    bus.wrEn   = 1'b0;
  endtask

  task automatic waitDrain(input string name, input int limit);
    int n = 0;
    while ((expQ.size() != 0 || bus.txBusy || bus.txStart) && n < limit) begin
      @(posedge clk);
      #3;
      n++;
    end
    check({name, "_drained"}, (expQ.size() == 0 && !bus.txBusy && !bus.txStart), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

  initial begin
    bus.wrEn   = 1'b0;
    bus.wrData = 8'h00;
    bus.ovfClr = 1'b0;
    #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Idle after reset.
    repeat (10) @(negedge clk);
    check("idle_txStart", bus.txStart, 0);
    check("idle_empty", bus.empty, 1);
    check("idle_count", bus.count, 0);
    check("idle_txIn", bus.txIn, 8'h00);

    // Single byte: latency and txBusy handshake timing.
    busyLen = 20;
    frames  = 0;
    @(negedge clk);
    bus.wrEn   = 1'b1;
    bus.wrData = 8'hA5;
    @(posedge clk);
    #2;
    check("lat_n_txStart", bus.txStart, 0);
    check("lat_n_empty", bus.empty, 0);
    @(negedge clk);
    bus.wrEn = 1'b0;
    @(posedge clk);
    #2;
    check("lat_n1_txStart", bus.txStart, 1);
    check("lat_n1_txIn", bus.txIn, 8'hA5);
    for (int i = 0; i <= SyncLat; i++) begin
      @(posedge clk);
      #2;
      check("start_fall", bus.txStart, (i == SyncLat) ? 0 : 1);
    end
    repeat (40) @(posedge clk);
    check("one_frame", frames, 1);
    waitDrain("single", 100);

    // Fill to full behind a stalled frame, then overflow.
    busyLen = 5;
    stall   = 1'b1;
    writeByte(8'h55);
    repeat (10) @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      bus.wrEn   = 1'b1;
      bus.wrData = 8'(i);
    end
    @(negedge clk);
    check("burst_full", bus.full, 1);
    check("burst_count", bus.count, 16);
    check("burst_ovf0", bus.overflow, 0);
    bus.wrData = 8'hFF;
    @(negedge clk);
    bus.wrEn = 1'b0;
    check("drop_ovf", bus.overflow, 1);
    check("drop_count", bus.count, 16);
    @(posedge clk);
    #3;
    stall = 1'b0;
    waitDrain("burst", 600);
    check("ovf_sticky", bus.overflow, 1);
    @(negedge clk);
    bus.ovfClr = 1'b1;
    @(negedge clk);
    bus.ovfClr = 1'b0;
    check("ovf_clr", bus.overflow, 0);

    // Write coinciding with a pop at count 3.
    stall = 1'b1;
    writeByte(8'h11);
    repeat (10) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.wrEn   = 1'b1;
      bus.wrData = 8'h21 + 8'(i);
    end
    @(negedge clk);
    bus.wrEn = 1'b0;
    check("pre_same_count", bus.count, 3);
    @(posedge clk);
    #3;
    stall = 1'b0;
    repeat (1 + SyncLat) @(posedge clk);
    @(negedge clk);
    bus.wrEn   = 1'b1;
    bus.wrData = 8'h24;
    @(posedge clk);
    #2;
    check("same_cycle_count", bus.count, 3);
    check("same_cycle_pop", bus.txStart, 1);
    @(negedge clk);
    bus.wrEn = 1'b0;
    waitDrain("same_cycle", 200);

    // Random traffic: many pointer wraps, drops and clears.
    randBusy = 1'b1;
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      bus.wrEn   = ($urandom_range(0, 2) == 0);
      bus.wrData = 8'($urandom);
      bus.ovfClr = ($urandom_range(0, 30) == 0);
    end
    @(negedge clk);
    bus.wrEn   = 1'b0;
    bus.ovfClr = 1'b0;
    waitDrain("random", 3000);
    randBusy = 1'b0;

    // Reset while waiting in START with a disabled transmitter.
    txEnable = 1'b0;
    writeByte(8'h3C);
    repeat (4) @(negedge clk);
    check("hold_txStart", bus.txStart, 1);
    check("hold_txIn", bus.txIn, 8'h3C);
    reset = 1'b1;
    #1;
    check("rst_txStart", bus.txStart, 0);
    check("rst_empty", bus.empty, 1);
    check("rst_txIn", bus.txIn, 8'h00);
    repeat (2) @(negedge clk);
    reset    = 1'b0;
    txEnable = 1'b1;
    writeByte(8'h7E);
    waitDrain("post_reset", 100);
    check("post_reset_byte", lastTx, 8'h7E);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
